// File: rtl/uc_pkg.sv
// Shared types and encodings for the multicycle control unit.
package uc_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StWaitIn,
    StHalt
  } state_t;

  // Instruction class, decoded from opcode[5:2]; ALU is any code with bit 3 set.
  localparam logic [3:0] OPC_ALU  = 4'b1000;
  localparam logic [3:0] OPC_LI   = 4'b0000;
  localparam logic [3:0] OPC_LD   = 4'b0001;
  localparam logic [3:0] OPC_ST   = 4'b0010;
  localparam logic [3:0] OPC_IN   = 4'b0011;
  localparam logic [3:0] OPC_OUTR = 4'b0100;
  localparam logic [3:0] OPC_OUTI = 4'b0101;
  localparam logic [3:0] OPC_JUMP = 4'b0110;
  localparam logic [3:0] OPC_MISC = 4'b0111;

  // Jump group sub-ops, opcode[1:0].
  localparam logic [1:0] JMP_J    = 2'b00;
  localparam logic [1:0] JMP_JZ   = 2'b01;
  localparam logic [1:0] JMP_JNZ  = 2'b10;
  localparam logic [1:0] JMP_CALL = 2'b11;

  // Misc group sub-ops, opcode[1:0].
  localparam logic [1:0] MISC_RET  = 2'b00;
  localparam logic [1:0] MISC_NOP  = 2'b01;
  localparam logic [1:0] MISC_HALT = 2'b10;
  localparam logic [1:0] MISC_NOP2 = 2'b11;

  // Writeback select.
  localparam logic [1:0] SINM_ALU = 2'd0;
  localparam logic [1:0] SINM_IMM = 2'd1;
  localparam logic [1:0] SINM_MEM = 2'd2;
  localparam logic [1:0] SINM_IN  = 2'd3;

  // Output port source select.
  localparam logic [1:0] SOUT_REG = 2'd0;
  localparam logic [1:0] SOUT_IMM = 2'd1;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       s_inc;
    logic       s_stack;
    logic       pushsignal;
    logic       popsignal;
    logic       we3;
    logic       wez;
    logic       we4;
    logic       we_out;
    logic [1:0] s_inm;
    logic [1:0] s_in;
    logic [1:0] s_out;
    logic [2:0] op_alu;
    logic       in_ack;
    logic       halted;
  } ctrl_t;

  function automatic logic is_in_op(logic [5:0] op);
    return op[5:2] == OPC_IN;
  endfunction

  function automatic logic is_halt_op(logic [5:0] op);
    return (op[5:2] == OPC_MISC) && (op[1:0] == MISC_HALT);
  endfunction

endpackage

// File: rtl/uc_multiciclo_if.sv
// Control bus between the control unit (master) and the datapath (slave).
interface uc_multiciclo_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic [5:0]       opcode;
  logic             z;
  logic             in_valid;
  logic             resume;
  logic             pc_en;
  logic             ir_en;
  logic             s_inc;
  logic             s_stack;
  logic             pushsignal;
  logic             popsignal;
  logic             we3;
  logic             wez;
  logic             we4;
  logic             we_out;
  logic [1:0]       s_inm;
  logic [1:0]       s_in;
  logic [1:0]       s_out;
  logic [2:0]       op_alu;
  logic             in_ack;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, z, in_valid, resume,
    output pc_en, ir_en, s_inc, s_stack, pushsignal, popsignal, we3, wez, we4, we_out,
    output s_inm, s_in, s_out, op_alu, in_ack, halted, instr_count
  );

  modport slave (
    output opcode, z, in_valid, resume,
    input  pc_en, ir_en, s_inc, s_stack, pushsignal, popsignal, we3, wez, we4, we_out,
    input  s_inm, s_in, s_out, op_alu, in_ack, halted, instr_count
  );

endinterface

// File: rtl/uc_decode.sv
// Combinational decode of state, latched opcode and Z into the control vector.
module uc_decode
  import uc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       in_valid,
  output ctrl_t      ctrl
);

  // Selects idle at their reset values; strobes only in EXEC or the WAIT_IN completion.
  always_comb begin
    ctrl       = '0;
    ctrl.s_inc = 1'b1;
    unique case (state)
      StFetch: ctrl.ir_en = 1'b1;
      StExec: begin
        ctrl.pc_en = 1'b1;
        unique casez (opcode[5:2])
          4'b1???: begin
            ctrl.we3    = 1'b1;
            ctrl.wez    = 1'b1;
            ctrl.s_inm  = SINM_ALU;
            ctrl.op_alu = opcode[4:2];
          end
          OPC_LI: begin
            ctrl.we3   = 1'b1;
            ctrl.s_inm = SINM_IMM;
          end
          OPC_LD: begin
            ctrl.we3   = 1'b1;
            ctrl.s_inm = SINM_MEM;
          end
          OPC_ST: ctrl.we4 = 1'b1;
          OPC_IN: begin
            ctrl.s_in  = opcode[1:0];
            ctrl.s_inm = SINM_IN;
            // Without data the IN parks in WAIT_IN and the PC must not move yet.
            if (in_valid) begin
              ctrl.we3    = 1'b1;
              ctrl.in_ack = 1'b1;
            end else begin
              ctrl.pc_en = 1'b0;
            end
          end
          OPC_OUTR: begin
            ctrl.we_out = 1'b1;
            ctrl.s_out  = SOUT_REG;
          end
          OPC_OUTI: begin
            ctrl.we_out = 1'b1;
            ctrl.s_out  = SOUT_IMM;
          end
          OPC_JUMP: begin
            unique case (opcode[1:0])
              JMP_J:   ctrl.s_inc = 1'b0;
              JMP_JZ:  ctrl.s_inc = ~z;
              JMP_JNZ: ctrl.s_inc = z;
              JMP_CALL: begin
                ctrl.s_inc      = 1'b0;
                ctrl.pushsignal = 1'b1;
              end
            endcase
          end
          OPC_MISC: begin
            unique case (opcode[1:0])
              MISC_RET: begin
                ctrl.s_stack   = 1'b1;
                ctrl.popsignal = 1'b1;
              end
              MISC_HALT: ctrl.pc_en = 1'b0;
              MISC_NOP, MISC_NOP2: ;
            endcase
          end
          default: ;
        endcase
      end
      StWaitIn: begin
        ctrl.s_in  = opcode[1:0];
        ctrl.s_inm = SINM_IN;
        if (in_valid) begin
          ctrl.we3    = 1'b1;
          ctrl.in_ack = 1'b1;
          ctrl.pc_en  = 1'b1;
        end
      end
      StHalt: ctrl.halted = 1'b1;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH/EXEC sequencer with IN wait, HALT and retire counter.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  uc_multiciclo_if.master bus
);

  state_t           state_q;
  logic [5:0]       opcode_q;
  logic [CNT_W-1:0] count_q;
  ctrl_t            ctrl;

  uc_decode u_decode (
    .state    (state_q),
    .opcode   (opcode_q),
    .z        (bus.z),
    .in_valid (bus.in_valid),
    .ctrl     (ctrl)
  );

  // Sequencer, instruction latch and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StFetch;
      opcode_q <= '0;
      count_q  <= '0;
    end else begin
      if (ctrl.ir_en) opcode_q <= bus.opcode;
      // A PC load marks retirement, so HALT and a stalled IN are not counted.
      if (ctrl.pc_en) count_q <= count_q + CNT_W'(1);
      unique case (state_q)
        StFetch: state_q <= StExec;
        StExec: begin
          if (is_in_op(opcode_q) && !bus.in_valid) state_q <= StWaitIn;
          else if (is_halt_op(opcode_q))           state_q <= StHalt;
          else                                     state_q <= StFetch;
        end
        StWaitIn: if (bus.in_valid) state_q <= StFetch;
        StHalt:   if (bus.resume)   state_q <= StFetch;
      endcase
    end
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ir_en       = ctrl.ir_en;
  assign bus.s_inc       = ctrl.s_inc;
  assign bus.s_stack     = ctrl.s_stack;
  assign bus.pushsignal  = ctrl.pushsignal;
  assign bus.popsignal   = ctrl.popsignal;
  assign bus.we3         = ctrl.we3;
  assign bus.wez         = ctrl.wez;
  assign bus.we4         = ctrl.we4;
  assign bus.we_out      = ctrl.we_out;
  assign bus.s_inm       = ctrl.s_inm;
  assign bus.s_in        = ctrl.s_in;
  assign bus.s_out       = ctrl.s_out;
  assign bus.op_alu      = ctrl.op_alu;
  assign bus.in_ack      = ctrl.in_ack;
  assign bus.halted      = ctrl.halted;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed self-checking bench for uc_multiciclo.
module tb_uc_multiciclo;

  logic clk = 1'b0;
  logic reset;
  logic reset4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        both_seen = 1'b0;

  uc_multiciclo_if #(.CNT_W(16)) bus ();
  uc_multiciclo_if #(.CNT_W(4))  bus4 ();

  uc_multiciclo #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  uc_multiciclo #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  // Push and pop must never be raised together.
  always @(negedge clk) if (bus.pushsignal && bus.popsignal) both_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Called in FETCH: present op, step into its EXEC cycle.
  task automatic fetch_exec(input logic [5:0] op);
    bus.opcode = op;
    cyc();
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    reset4        = 1'b0;
    bus.opcode    = 6'b000000;
    bus.z         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.resume    = 1'b0;
    bus4.opcode   = 6'b011101;
    bus4.z        = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.resume   = 1'b0;
    #1;
    check("rst_count", 32'(bus.instr_count), 0);
    check("rst_pc_en", 32'(bus.pc_en), 0);
    check("rst_s_inc", 32'(bus.s_inc), 1);
    check("rst_halted", 32'(bus.halted), 0);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("fetch_ir_en", 32'(bus.ir_en), 1);
    check("fetch_we3", 32'(bus.we3), 0);

    // LI then ALU add
    fetch_exec(6'b000000);
    check("li_we3", 32'(bus.we3), 1);
    check("li_s_inm", 32'(bus.s_inm), 1);
    check("li_pc_en", 32'(bus.pc_en), 1);
    check("li_wez", 32'(bus.wez), 0);
    cyc();
    check("li_fetch_pc_en", 32'(bus.pc_en), 0);
    fetch_exec(6'b100000);
    check("alu_we3_wez", {30'd0, bus.we3, bus.wez}, 3);
    check("alu_op", 32'(bus.op_alu), 0);
    check("alu_s_inm", 32'(bus.s_inm), 0);
    check("alu_pc_en", 32'(bus.pc_en), 1);
    cyc();
    check("count_2", 32'(bus.instr_count), 2);

    // Conditional jumps
    bus.z = 1'b1;
    fetch_exec(6'b011001);
    check("jz_taken_s_inc", 32'(bus.s_inc), 0);
    check("jz_pc_en", 32'(bus.pc_en), 1);
    cyc();
    bus.z = 1'b0;
    fetch_exec(6'b011001);
    check("jz_not_taken_s_inc", 32'(bus.s_inc), 1);
    cyc();
    fetch_exec(6'b011010);
    check("jnz_taken_s_inc", 32'(bus.s_inc), 0);
    cyc();

    // CALL then RET
    fetch_exec(6'b011011);
    check("call_push", 32'(bus.pushsignal), 1);
    check("call_s_inc", 32'(bus.s_inc), 0);
    check("call_pop", 32'(bus.popsignal), 0);
    cyc();
    fetch_exec(6'b011100);
    check("ret_pop", 32'(bus.popsignal), 1);
    check("ret_s_stack", 32'(bus.s_stack), 1);
    check("ret_push", 32'(bus.pushsignal), 0);
    cyc();
    check("count_7", 32'(bus.instr_count), 7);

    // IN from port 2, data arrives late
    fetch_exec(6'b001110);
    check("in_stall_strobes", {29'd0, bus.we3, bus.in_ack, bus.pc_en}, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("wait_in_strobes", {29'd0, bus.we3, bus.in_ack, bus.pc_en}, 0);
    end
    bus.in_valid = 1'b1;
    #1;
    check("in_done_strobes", {29'd0, bus.we3, bus.in_ack, bus.pc_en}, 7);
    check("in_done_s_inm", 32'(bus.s_inm), 3);
    check("in_done_s_in", 32'(bus.s_in), 2);
    cyc();
    bus.in_valid = 1'b0;
    check("in_back_fetch", 32'(bus.ir_en), 1);
    check("count_8", 32'(bus.instr_count), 8);

    // HALT and resume
    fetch_exec(6'b011110);
    check("halt_exec_pc_en", 32'(bus.pc_en), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("halted", {30'd0, bus.halted, bus.pc_en}, 2);
    end
    bus.resume = 1'b1;
    cyc();
    bus.resume = 1'b0;
    check("resume_fetch", {30'd0, bus.halted, bus.ir_en}, 1);
    check("halt_not_counted", 32'(bus.instr_count), 8);

    // Reset during WAIT_IN
    fetch_exec(6'b001101);
    cyc();
    check("wait_in_s_inm", 32'(bus.s_inm), 3);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    check("rst_wait_in_ack", 32'(bus.in_ack), 0);
    check("rst_wait_selects", {26'd0, bus.s_inm, bus.s_in, bus.s_out}, 0);
    check("rst_wait_count", 32'(bus.instr_count), 0);
    check("rst_wait_fetch", 32'(bus.ir_en), 1);
    cyc();
    check("rst_held_ack", 32'(bus.in_ack), 0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    fetch_exec(6'b011101);
    check("nop_after_rst", 32'(bus.pc_en), 1);
    check("nop_no_strobe", {28'd0, bus.we3, bus.we4, bus.we_out, bus.wez}, 0);
    cyc();

    // 4-bit counter wrap using a stream of NOPs
    reset4 = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    check("cnt4_at_15", 32'(bus4.instr_count), 15);
    cyc();
    cyc();
    check("cnt4_wrap", 32'(bus4.instr_count), 0);

    check("push_pop_excl", 32'(both_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
